// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding-request instruction fetch stage.
//                Issues one instruction-memory request at the current PC,
//                waits for its response, registers the instruction for
//                decode, and loads the next PC from an external selector.
//                Redirects (flush) may arrive in any state; a response that
//                belongs to a flushed request is swallowed in DROP.
//
//  Ports       : clk, rst            - clock, async active-high reset
//                pc / pc_next        - current PC out, next PC in
//                flush               - redirect, pc_next holds the target
//                imem_req_*          - memory request (valid/ready/addr)
//                imem_resp_*         - memory response (valid/data)
//                if_valid/if_ready   - handshake towards decode
//                if_inst / if_pc     - registered instruction and its PC
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  flush,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic [ADDR_WIDTH-1:0] if_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // request outstanding on the bus, address = pc
        S_WAIT = 2'd1,   // request accepted, waiting for its response
        S_OUT  = 2'd2,   // instruction presented to decode
        S_DROP = 2'd3    // waiting to swallow the response of a flushed request
    } state_t;

    // Reset PC with the low two bits already cleared.
    localparam logic [ADDR_WIDTH-1:0] c_reset_pc = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [INST_WIDTH-1:0] r_if_inst;
    logic [ADDR_WIDTH-1:0] r_if_pc;
    logic                  w_pc_load;
    logic                  w_capture;

    // ------------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_load    = 1'b0;
        w_capture    = 1'b0;

        case (r_state)
            S_REQ: begin
                // A flush outranks a same-cycle handshake: the request is
                // considered not accepted and the address moves on.
                if (flush) begin
                    w_pc_load = 1'b1;
                end else if (imem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (flush) begin
                    w_pc_load = 1'b1;
                    // A response arriving with the flush closes the old
                    // request immediately; otherwise it is still in flight.
                    w_state_next = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_OUT;
                end
            end

            S_OUT: begin
                if (flush || if_ready) begin
                    w_pc_load    = 1'b1;
                    w_state_next = S_REQ;
                end
            end

            S_DROP: begin
                if (flush) begin
                    w_pc_load = 1'b1;
                end
                if (imem_resp_valid) begin
                    w_state_next = S_REQ;
                end
            end

            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, PC and instruction registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= c_reset_pc;
            r_if_inst <= '0;
            r_if_pc   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pc_load) begin
                r_pc <= {pc_next[ADDR_WIDTH-1:2], 2'b00};
            end
            if (w_capture) begin
                r_if_inst <= imem_resp_data;
                r_if_pc   <= r_pc;
            end
        end
    end

    // Outputs decoded purely from registered state.
    assign pc             = r_pc;
    assign imem_req_addr  = r_pc;
    assign imem_req_valid = (r_state == S_REQ);
    assign if_valid       = (r_state == S_OUT);
    assign if_inst        = r_if_inst;
    assign if_pc          = r_if_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Inputs change
//                on the falling edge, outputs are compared on the falling
//                edge (or shortly after an async reset assertion).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    wire  [63:0] pc;
    wire  [63:0] pc_next;
    logic        flush;
    wire         imem_req_valid;
    logic        imem_req_ready;
    wire  [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    wire         if_valid;
    logic        if_ready;
    wire  [31:0] if_inst;
    wire  [63:0] if_pc;

    // Next-PC selector: pc+4 unless a directed target is forced.
    logic        use_ovr;
    logic [63:0] ovr;
    assign pc_next = use_ovr ? ovr : pc + 64'd4;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .ADDR_WIDTH(64),
        .INST_WIDTH(32),
        .RESET_PC  (64'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_next        (pc_next),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and return on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (if_valid !== 1'b0)       begin errors++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        checks++; if (pc !== 64'h0)            begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
        checks++; if (if_inst !== 32'h0)       begin errors++; $display("FAIL reset_if_inst: got %h expected 0", if_inst); end
        checks++; if (if_pc !== 64'h0)         begin errors++; $display("FAIL reset_if_pc: got %h expected 0", if_pc); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset release, one full REQ/WAIT/OUT pass at address 0.
    task automatic test_basic();
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL basic_req_addr: got %h expected 0", imem_req_addr); end
        cyc();                                  // WAIT
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0013;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_req_valid: got %b expected 0", imem_req_valid); end
        cyc();                                  // OUT
        imem_resp_valid = 1'b0;
        checks++; if (if_valid !== 1'b1)          begin errors++; $display("FAIL basic_if_valid: got %b expected 1", if_valid); end
        checks++; if (if_inst !== 32'h0000_0013)  begin errors++; $display("FAIL basic_if_inst: got %h expected 00000013", if_inst); end
        checks++; if (if_pc !== 64'h0)            begin errors++; $display("FAIL basic_if_pc: got %h expected 0", if_pc); end
        cyc();                                  // REQ at pc+4
        checks++; if (imem_req_valid !== 1'b1)    begin errors++; $display("FAIL basic_next_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 64'h4)    begin errors++; $display("FAIL basic_next_req_addr: got %h expected 4", imem_req_addr); end
    endtask

    // Decode back-pressure holds everything stable in OUT.
    task automatic test_stall_out();
        imem_req_ready = 1'b1;
        cyc();                                  // WAIT
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        if_ready        = 1'b0;
        cyc();                                  // OUT
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_valid !== 1'b1)         begin errors++; $display("FAIL stall_if_valid[%0d]: got %b expected 1", i, if_valid); end
            checks++; if (if_inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_if_inst[%0d]: got %h expected deadbeef", i, if_inst); end
            checks++; if (if_pc !== 64'h4)           begin errors++; $display("FAIL stall_if_pc[%0d]: got %h expected 4", i, if_pc); end
            checks++; if (pc !== 64'h4)              begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 4", i, pc); end
            checks++; if (imem_req_valid !== 1'b0)   begin errors++; $display("FAIL stall_req_valid[%0d]: got %b expected 0", i, imem_req_valid); end
            cyc();
        end
        if_ready = 1'b1;
        cyc();                                  // REQ at 8
        checks++; if (imem_req_addr !== 64'h8)  begin errors++; $display("FAIL stall_release_addr: got %h expected 8", imem_req_addr); end
        checks++; if (imem_req_valid !== 1'b1)  begin errors++; $display("FAIL stall_release_valid: got %b expected 1", imem_req_valid); end
    endtask

    // Flush in WAIT, late response swallowed in DROP.
    task automatic test_flush_wait();
        imem_req_ready = 1'b1;
        cyc();                                  // WAIT
        imem_req_ready = 1'b0;
        flush   = 1'b1;
        use_ovr = 1'b1;
        ovr     = 64'h100;
        cyc();                                  // DROP, pc=0x100
        flush   = 1'b0;
        use_ovr = 1'b0;
        checks++; if (if_valid !== 1'b0)       begin errors++; $display("FAIL drop_if_valid0: got %b expected 0", if_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_req_valid: got %b expected 0", imem_req_valid); end
        cyc();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        checks++; if (if_valid !== 1'b0)       begin errors++; $display("FAIL drop_if_valid1: got %b expected 0", if_valid); end
        cyc();                                  // REQ at 0x100
        imem_resp_valid = 1'b0;
        checks++; if (if_valid !== 1'b0)       begin errors++; $display("FAIL drop_if_valid2: got %b expected 0", if_valid); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL drop_next_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 64'h100) begin errors++; $display("FAIL drop_next_req_addr: got %h expected 100", imem_req_addr); end
        checks++; if (if_inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL drop_if_inst_kept: got %h expected deadbeef", if_inst); end
    endtask

    // Flush and response in the same WAIT cycle.
    task automatic test_flush_resp();
        imem_req_ready = 1'b1;
        cyc();                                  // WAIT
        imem_req_ready  = 1'b0;
        flush           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_2222;
        use_ovr         = 1'b1;
        ovr             = 64'h200;
        cyc();                                  // REQ at 0x200
        flush           = 1'b0;
        imem_resp_valid = 1'b0;
        use_ovr         = 1'b0;
        checks++; if (if_valid !== 1'b0)         begin errors++; $display("FAIL fr_if_valid: got %b expected 0", if_valid); end
        checks++; if (imem_req_valid !== 1'b1)   begin errors++; $display("FAIL fr_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 64'h200) begin errors++; $display("FAIL fr_req_addr: got %h expected 200", imem_req_addr); end
    endtask

    // Memory stall in REQ, then flushes with misaligned and competing targets.
    task automatic test_req_stall();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (imem_req_valid !== 1'b1)   begin errors++; $display("FAIL rs_valid[%0d]: got %b expected 1", i, imem_req_valid); end
            checks++; if (imem_req_addr !== 64'h200) begin errors++; $display("FAIL rs_addr[%0d]: got %h expected 200", i, imem_req_addr); end
        end
        flush   = 1'b1;
        use_ovr = 1'b1;
        ovr     = 64'h303;
        cyc();
        checks++; if (imem_req_addr !== 64'h300) begin errors++; $display("FAIL rs_flush_addr: got %h expected 300", imem_req_addr); end
        checks++; if (imem_req_valid !== 1'b1)   begin errors++; $display("FAIL rs_flush_valid: got %b expected 1", imem_req_valid); end
        // Flush wins over a same-cycle handshake: still requesting, new address.
        imem_req_ready = 1'b1;
        ovr            = 64'h400;
        cyc();
        imem_req_ready = 1'b0;
        flush          = 1'b0;
        use_ovr        = 1'b0;
        checks++; if (imem_req_valid !== 1'b1)   begin errors++; $display("FAIL rs_flushwin_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 64'h400) begin errors++; $display("FAIL rs_flushwin_addr: got %h expected 400", imem_req_addr); end
    endtask

    // Flush while presenting to decode voids the instruction.
    task automatic test_out_flush();
        imem_req_ready = 1'b1;
        cyc();                                  // WAIT
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0040_0093;
        if_ready        = 1'b0;
        cyc();                                  // OUT
        imem_resp_valid = 1'b0;
        checks++; if (if_pc !== 64'h400)         begin errors++; $display("FAIL of_if_pc: got %h expected 400", if_pc); end
        flush   = 1'b1;
        use_ovr = 1'b1;
        ovr     = 64'h500;
        cyc();                                  // REQ at 0x500
        flush   = 1'b0;
        use_ovr = 1'b0;
        checks++; if (if_valid !== 1'b0)         begin errors++; $display("FAIL of_if_valid: got %b expected 0", if_valid); end
        checks++; if (imem_req_addr !== 64'h500) begin errors++; $display("FAIL of_req_addr: got %h expected 500", imem_req_addr); end
    endtask

    // Asynchronous reset while in OUT takes effect before the next edge.
    task automatic test_async_reset();
        imem_req_ready = 1'b1;
        cyc();                                  // WAIT
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h7777_7777;
        cyc();                                  // OUT
        imem_resp_valid = 1'b0;
        checks++; if (if_valid !== 1'b1)       begin errors++; $display("FAIL ar_pre_if_valid: got %b expected 1", if_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (if_valid !== 1'b0)       begin errors++; $display("FAIL ar_if_valid: got %b expected 0", if_valid); end
        checks++; if (pc !== 64'h0)            begin errors++; $display("FAIL ar_pc: got %h expected 0", pc); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL ar_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (if_inst !== 32'h0)       begin errors++; $display("FAIL ar_if_inst: got %h expected 0", if_inst); end
        @(negedge clk);
        rst = 1'b0;
        cyc();
        checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL ar_post_addr: got %h expected 0", imem_req_addr); end
    endtask

    initial begin
        rst             = 1'b0;
        flush           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if_ready        = 1'b0;
        use_ovr         = 1'b0;
        ovr             = 64'h0;

        test_reset();
        test_basic();
        test_stall_out();
        test_flush_wait();
        test_flush_resp();
        test_req_stall();
        test_out_flush();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
